embertrail_data_bus_ctrl: RTL and testbench



---
 rtl/embertrail_pkg.sv | 9 +
 rtl/embertrail_bank_decode.sv | 28 ++
 rtl/embertrail_data_bus_ctrl.sv | 104 ++++++++++
 tb/tb_embertrail_data_bus_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/embertrail_pkg.sv
// embertrail_pkg: shared FSM states, RW encoding and bank-index sizing for the data bus controller
package embertrail_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction
endpackage

// File: rtl/embertrail_bank_decode.sv
// embertrail_bank_decode: turns a bank index into one-hot bus-enable/RW strobes and flags missing banks
module embertrail_bank_decode
    import embertrail_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_BITS = 1
)(
    input  logic [BANK_BITS-1:0] i_bank,
    input  logic                 i_en,
    input  logic                 i_write,
    output logic [NUM_BANKS-1:0] o_bus_en,
    output logic [NUM_BANKS-1:0] o_rw,
    output logic                 o_valid
);
    localparam int IDX_W = bank_idx_w(NUM_BANKS);
    logic [BANK_BITS-1:0] w_hi;
    assign w_hi    = i_bank >> IDX_W;
    // any set bit above the index width, or an index past the last bank, is a missing bank
    assign o_valid = (w_hi == '0) && (int'(i_bank[IDX_W-1:0]) < NUM_BANKS);
    always_comb begin
        o_bus_en = '0;
        o_rw     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            o_bus_en[b] = i_en && o_valid && (i_bank[IDX_W-1:0] == IDX_W'(b));
            o_rw[b]     = o_bus_en[b] && (i_write == MEM_WRITE);
        end
    end
endmodule

// File: rtl/embertrail_data_bus_ctrl.sv
// embertrail_data_bus_ctrl: req/ready controller steering one core port onto NUM_BANKS data-memory banks
module embertrail_data_bus_ctrl
    import embertrail_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_BANKS   = 2,
    parameter int BANK_BITS   = 1,
    parameter int WAIT_CYCLES = 0
)(
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iReq,
    input  logic                  iWrite,
    input  logic [ADDR_W-1:0]     iAddr,
    input  logic [DATA_W-1:0]     iWData,
    output logic [DATA_W-1:0]     oRData,
    output logic                  oReady,
    output logic                  oErr,
    output logic                  oBusy,
    output logic [ADDR_W-BANK_BITS-1:0] oMemAddr,
    output logic [DATA_W-1:0]     oMemWData,
    input  logic [DATA_W-1:0]     iMemRData,
    output logic [NUM_BANKS-1:0]  oMemRW,
    output logic [NUM_BANKS-1:0]  oMemBusEn
);
    localparam int OFF_W = ADDR_W - BANK_BITS;
    state_t               r_state;
    logic [3:0]           r_wait;
    logic                 r_write;
    logic                 w_accept;
    logic                 w_bank_valid;
    logic [NUM_BANKS-1:0] w_bus_en;
    logic [NUM_BANKS-1:0] w_rw;
    assign w_accept = (r_state == IDLE) && iReq;
    embertrail_bank_decode #(
        .NUM_BANKS(NUM_BANKS),
        .BANK_BITS(BANK_BITS)
    ) u_dec (
        .i_bank  (iAddr[ADDR_W-1 -: BANK_BITS]),
        .i_en    (w_accept),
        .i_write (iWrite),
        .o_bus_en(w_bus_en),
        .o_rw    (w_rw),
        .o_valid (w_bank_valid)
    );
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state   <= IDLE;
            r_wait    <= '0;
            r_write   <= MEM_READ;
            oRData    <= '0;
            oReady    <= 1'b0;
            oErr      <= 1'b0;
            oBusy     <= 1'b0;
            oMemAddr  <= '0;
            oMemWData <= '0;
            oMemRW    <= '0;
            oMemBusEn <= '0;
        end else begin
            case (r_state)
                IDLE: if (iReq) begin
                    r_write   <= iWrite;
                    oMemAddr  <= iAddr[OFF_W-1:0];
                    oMemWData <= iWData;
                    oBusy     <= 1'b1;
                    if (w_bank_valid) begin
                        r_state   <= ACCESS;
                        r_wait    <= 4'(WAIT_CYCLES);
                        oMemBusEn <= w_bus_en;
                        oMemRW    <= w_rw;
                    end else begin
                        r_state <= ERR;
                        oReady  <= 1'b1;
                        oErr    <= 1'b1;
                    end
                end
                ACCESS: if (r_wait == '0) begin
                    if (r_write == MEM_READ) oRData <= iMemRData;
                    oMemBusEn <= '0;
                    oMemRW    <= '0;
                    oReady    <= 1'b1;
                    r_state   <= DONE;
                end else begin
                    r_wait <= r_wait - 4'd1;
                end
                DONE: begin
                    oReady  <= 1'b0;
                    oBusy   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    oReady  <= 1'b0;
                    oErr    <= 1'b0;
                    oBusy   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge iClock) begin
        if (!iReset) assert ($onehot0(oMemBusEn));
    end
endmodule

// File: tb/tb_embertrail_data_bus_ctrl.sv
// tb_embertrail_data_bus_ctrl: directed and random transfers against a banked memory model with a ready scoreboard
module tb_embertrail_data_bus_ctrl;
    localparam int W = 2;
    localparam int NB = 3;
    localparam int LAT = 2 + W;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic        iReq = 1'b0;
    logic        iWrite = 1'b0;
    logic [31:0] iAddr = '0;
    logic [31:0] iWData = '0;
    logic [31:0] oRData;
    logic        oReady, oErr, oBusy;
    logic [29:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData;
    logic [NB-1:0] oMemRW, oMemBusEn;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    exp_t q[$];
    logic [31:0] last_rd = '0;
    logic [31:0] sh_mem [128];
    bit   [127:0] sh_wr;
    logic [31:0] mm [128];
    bit   [127:0] mw;
    logic [6:0]  mk;

    embertrail_data_bus_ctrl #(
        .DATA_W(32), .ADDR_W(32), .NUM_BANKS(NB), .BANK_BITS(2), .WAIT_CYCLES(W)
    ) dut (
        .iClock(clk), .iReset(iReset), .iReq(iReq), .iWrite(iWrite), .iAddr(iAddr),
        .iWData(iWData), .oRData(oRData), .oReady(oReady), .oErr(oErr), .oBusy(oBusy),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemRData(iMemRData),
        .oMemRW(oMemRW), .oMemBusEn(oMemBusEn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [6:0] k);
        return (k == 7'h50) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(k));
    endfunction

    function automatic logic [1:0] bidx(input logic [NB-1:0] oh);
        return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
    endfunction

    // banked memory: shared read bus, writes land while the enabled bank sees RW=1
    always_comb begin
        mk = {bidx(oMemBusEn), oMemAddr[4:0]};
        iMemRData = (oMemBusEn == '0) ? 32'h0 : (mw[mk] ? mm[mk] : pat(mk));
    end
    always @(posedge clk) begin
        if ((oMemBusEn & oMemRW) != '0) begin
            mm[mk] <= oMemWData;
            mw[mk] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!iReset) begin
            chk("onehot0_bus_en", 64'($onehot0(oMemBusEn)), 64'(1));
            if (oReady) begin
                if (q.size() == 0) chk("unexpected_ready", 64'(1), 64'(0));
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ready_cycle", 64'(cyc), 64'(e.cyc));
                    chk("err", 64'(oErr), 64'(e.err));
                    chk("rdata", 64'(oRData), 64'(e.rd));
                end
            end
        end
    end

    task automatic xfer(input logic w, input logic [1:0] bank, input logic [4:0] off,
                        input logic [31:0] wd, input bit hold);
        logic [6:0]    k;
        logic          err;
        logic [NB-1:0] oh;
        int            t, lat;
        @(negedge clk);
        iReq = 1'b1;
        iWrite = w;
        iAddr = {bank, 25'd0, off};
        iWData = wd;
        t = cyc;
        k = {bank, off};
        err = (bank >= 2'(NB));
        lat = err ? 1 : LAT;
        oh = err ? '0 : NB'(1 << bank);
        if (!err && !w) last_rd = sh_wr[k] ? sh_mem[k] : pat(k);
        if (!err && w) begin
            sh_mem[k] = wd;
            sh_wr[k] = 1'b1;
        end
        q.push_back('{t + lat, err, last_rd});
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i < lat) begin
                chk("access_strobes", 64'({oMemBusEn, oMemRW, oBusy}), 64'({oh, w ? oh : NB'(0), 1'b1}));
                chk("mem_addr", 64'(oMemAddr), 64'({25'd0, off}));
                if (w) chk("mem_wdata", 64'(oMemWData), 64'(wd));
            end else begin
                chk("final_strobes", 64'({oMemBusEn, oMemRW, oBusy}), 64'({NB'(0), NB'(0), 1'b1}));
            end
        end
        if (!hold) iReq = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 64'(oBusy), 64'(0));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({oReady, oErr, oBusy, oMemBusEn, oMemRW}), 64'(0));
        chk("reset_rdata_addr", 64'({oRData, oMemAddr}), 64'(0));
        chk("reset_wdata", 64'(oMemWData), 64'(0));
        iReset = 1'b0;
        idle(2);
        // read from bank 2 offset 0x10 (address 0x8000_0010)
        xfer(1'b0, 2'd2, 5'h10, 32'h0, 1'b0);
        idle(1);
        xfer(1'b1, 2'd0, 5'h04, 32'h12345678, 1'b0);
        idle(1);
        xfer(1'b0, 2'd0, 5'h04, 32'h0, 1'b0);
        xfer(1'b0, 2'd3, 5'h01, 32'h0, 1'b0);
        idle(2);
        // back-to-back with iReq held through DONE
        xfer(1'b1, 2'd1, 5'h07, 32'hCAFE0001, 1'b1);
        xfer(1'b0, 2'd1, 5'h07, 32'h0, 1'b1);
        xfer(1'b0, 2'd3, 5'h00, 32'h0, 1'b1);
        xfer(1'b0, 2'd2, 5'h1F, 32'h0, 1'b0);
        idle(1);
        // reset two cycles into an access: no completion for it
        @(negedge clk);
        iReq = 1'b1;
        iWrite = 1'b0;
        iAddr = {2'd1, 25'd0, 5'd3};
        @(negedge clk);
        iReq = 1'b0;
        @(negedge clk);
        iReset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", 64'({oReady, oErr, oBusy, oMemBusEn, oMemRW}), 64'(0));
        chk("midreset_rdata", 64'(oRData), 64'(0));
        chk("midreset_addr", 64'(oMemAddr), 64'(0));
        iReset = 1'b0;
        last_rd = '0;
        idle(4);
        xfer(1'b0, 2'd1, 5'd3, 32'h0, 1'b0);
        idle(1);
        for (int n = 0; n < 60; n++) begin
            bit h;
            h = 1'($urandom_range(0, 1));
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                 $urandom, h);
            if (!h) idle(1);
        end
        iReq = 1'b0;
        idle(6);
        chk("pending_responses", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
